// File: rtl/tt_mux_sel_pkg.sv
// Shared state encoding and default sizing for the TinyTapeout project-mux
// select controller.
package tt_mux_sel_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_PULSE_CYC = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DISABLE = 3'd1,
    RST_LO  = 3'd2,
    RST_HI  = 3'd3,
    INC_HI  = 3'd4,
    INC_LO  = 3'd5,
    FIN     = 3'd6
  } state_e;

  // Every state except IDLE and FIN holds for a full pulse phase.
  function automatic logic is_timed(state_e s);
    return (s != IDLE) && (s != FIN);
  endfunction

endpackage

// File: rtl/tt_mux_phase_timer.sv
// Loadable down-counter shared by every timed pulse phase; tc_o flags the
// last cycle of the phase.
module tt_mux_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// Sequences the three-wire TinyTapeout mux select interface from a request
// handshake. Define TT_MUX_SEL_INCR_EN to allow incremental selection.
//
// Handshake: a request is accepted on a clk edge where req_valid and
// req_ready are both 1; req_addr/req_ena are captured on that edge and
// ignored afterwards. req_ready is 1 only in IDLE, so a request held while
// busy is taken on the first IDLE cycle. done pulses for the single FIN cycle.
module tt_mux_sel_ctrl
  import tt_mux_sel_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PULSE_CYC = DEF_PULSE_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic [2:0]        dbg_state
);

  if (PULSE_CYC < 1) begin : g_pulse_cyc_check
    $error("PULSE_CYC must be at least 1");
  end

  localparam int TMR_W = $clog2(PULSE_CYC + 1);
  localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(PULSE_CYC - 1);

  state_e            state_q, state_d;
  logic              live_q;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] inc_cnt_q, inc_cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              ena_q, ena_d;
  logic              cur_valid_q, cur_valid_d;
  logic              ctrl_ena_q, ctrl_ena_d;
  logic              accept;
  logic              tmr_load;
  logic              tmr_tc;
`ifdef TT_MUX_SEL_INCR_EN
  logic              skip_q, skip_d;
`endif

  // live_q keeps the pads in their reset pattern until the first edge after release.
  assign req_ready      = live_q && (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign ctrl_sel_rst_n = live_q && (state_q != RST_LO);
  assign ctrl_sel_inc   = (state_q == INC_HI);
  assign ctrl_ena       = ctrl_ena_q;
  assign cur_addr       = cur_addr_q;
  assign cur_valid      = cur_valid_q;
  assign dbg_state      = state_q;

  assign accept   = req_valid && req_ready;
  assign tmr_load = (state_d != state_q) && is_timed(state_d);

  tt_mux_phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_ni     (reset_n),
    .load_i     (tmr_load),
    .load_val_i (PHASE_LOAD),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    ena_d       = ena_q;
    inc_cnt_d   = inc_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    ctrl_ena_d  = ctrl_ena_q;
`ifdef TT_MUX_SEL_INCR_EN
    skip_d      = skip_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = DISABLE;
          target_d    = req_addr;
          ena_d       = req_ena;
          ctrl_ena_d  = 1'b0;
          cur_valid_d = 1'b0;
`ifdef TT_MUX_SEL_INCR_EN
          // Only count upward from a known position; otherwise re-home.
          skip_d      = cur_valid_q && (req_addr >= cur_addr_q);
          inc_cnt_d   = req_addr - cur_addr_q;
`endif
        end
      end
      DISABLE: begin
        if (tmr_tc) begin
`ifdef TT_MUX_SEL_INCR_EN
          if (skip_q) begin
            state_d = (inc_cnt_q != '0) ? INC_HI : FIN;
          end else begin
            state_d = RST_LO;
          end
`else
          state_d = RST_LO;
`endif
        end
      end
      RST_LO: begin
        if (tmr_tc) begin
          state_d   = RST_HI;
          inc_cnt_d = target_q;
        end
      end
      RST_HI: begin
        if (tmr_tc) state_d = (inc_cnt_q != '0) ? INC_HI : FIN;
      end
      INC_HI: begin
        if (tmr_tc) state_d = INC_LO;
      end
      INC_LO: begin
        if (tmr_tc) begin
          inc_cnt_d = inc_cnt_q - ADDR_W'(1);
          state_d   = (inc_cnt_q != ADDR_W'(1)) ? INC_HI : FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == FIN) && (state_q != FIN)) begin
      ctrl_ena_d  = ena_q;
      cur_addr_d  = target_q;
      cur_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q      <= 1'b0;
      target_q    <= '0;
      ena_q       <= 1'b0;
      inc_cnt_q   <= '0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      ctrl_ena_q  <= 1'b0;
`ifdef TT_MUX_SEL_INCR_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      live_q      <= 1'b1;
      target_q    <= target_d;
      ena_q       <= ena_d;
      inc_cnt_q   <= inc_cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      ctrl_ena_q  <= ctrl_ena_d;
`ifdef TT_MUX_SEL_INCR_EN
      skip_q      <= skip_d;
`endif
    end
  end

endmodule

// File: doc/tt_mux_sel_ctrl.md
Name: tt_mux_sel_ctrl

Overview:
- Drives the three-wire TinyTapeout project-mux select interface (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena) from a simple request handshake.
- Generalises the fixed firmware bit-bang sequence: reset the select counter, pulse inc N times, then optionally enable the project.
- Timing of every pulse phase and the address width are parameters.
- Sits in the management/harness logic, between a CPU-side register block and the mux control pads.

Parameters:
- ADDR_W, 10: project address width; the largest selectable address is 2^ADDR_W-1.
- PULSE_CYC, 4: clk cycles per pulse phase (high or low); must be at least 1, checked at elaboration.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  select request valid
- req_ready  out  1  block idle and able to accept a request
- req_addr  in  ADDR_W  target project address
- req_ena  in  1  assert ctrl_ena once the selection completes
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes
- cur_addr  out  ADDR_W  address currently selected on the mux
- cur_valid  out  1  cur_addr is known to be correct
- ctrl_sel_rst_n  out  1  mux select-counter reset, active low
- ctrl_sel_inc  out  1  mux select-counter increment pulse
- ctrl_ena  out  1  mux project enable

Behaviour:
- Reset is asynchronous and active low. While reset_n=0 the outputs are:
  - ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0
  - req_ready=0, busy=0, done=0
  - cur_addr=0, cur_valid=0
- From the first clk edge after reset_n rises: state is IDLE, ctrl_sel_rst_n=1, req_ready=1.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on an edge where req_valid and req_ready are both 1.
  - req_addr and req_ena are captured on that edge; the inputs are don't-care afterwards.
- State sequence, with each timed phase lasting exactly PULSE_CYC cycles:
  - DISABLE: ctrl_ena=0 and cur_valid=0.
  - RST_LO: ctrl_sel_rst_n=0.
  - RST_HI: ctrl_sel_rst_n=1. The internal remaining-increment count is loaded with the target address.
  - INC_HI: ctrl_sel_inc=1.
  - INC_LO: ctrl_sel_inc=0. The count decrements on leaving INC_LO. If the count is nonzero the FSM returns to INC_HI, otherwise it goes to FIN.
  - FIN: lasts 1 cycle, then IDLE.
- Transitions out of RST_HI: to INC_HI if the count is nonzero, to FIN if it is zero (addr 0 produces no inc pulses).
- Entering FIN (registered, all on the same edge):
  - ctrl_ena<=req_ena
  - cur_addr<=target, cur_valid<=1
  - done=1 for exactly one cycle
- busy=1 in every state except IDLE. busy=~req_ready outside reset.
- Latency from acceptance edge to the done cycle, full path: (3+2*addr)*PULSE_CYC+1 cycles.
- Counters:
  - Phase counter width is clog2(PULSE_CYC+1). It loads PULSE_CYC-1 on phase entry.
  - Increment counter is ADDR_W bits and never wraps. Address 2^ADDR_W-1 produces exactly 2^ADDR_W-1 pulses.
- ctrl_sel_inc and ctrl_sel_rst_n are never low/high simultaneously outside RST phases. ctrl_sel_inc=0 in all non-INC_HI states.
- A reset_n assertion mid-sequence aborts immediately and all outputs return to reset values. The mux is then treated as unknown (cur_valid=0).
- req_valid held during busy is ignored and accepted only once back in IDLE. A back-to-back request is accepted on the first IDLE cycle after FIN.

Optional Feature:
- Macro: TT_MUX_SEL_INCR_EN.
- Defined: if cur_valid=1 and req_addr>=cur_addr at acceptance, the FSM skips RST_LO/RST_HI. It goes from DISABLE straight to the INC loop with count=req_addr-cur_addr, or to FIN if the difference is zero.
  - Latency is (1+2*diff)*PULSE_CYC+1.
  - If req_addr<cur_addr or cur_valid=0, the full path is taken.
- Undefined: the full reset path is always taken, and the comparison/subtract logic is absent.

Decomposition:
- Package tt_mux_sel_pkg holds:
  - the state enum: IDLE, DISABLE, RST_LO, RST_HI, INC_HI, INC_LO, FIN
  - the default PULSE_CYC and ADDR_W constants
- One sub-module, tt_mux_phase_timer: loadable down-counter with a terminal-count flag, reused by every timed phase.

Test Plan:
- Reset release, no request: outputs hold rst_n=1, inc=0, ena=0, req_ready=1, cur_valid=0 for 20 cycles.
- PULSE_CYC=4, req addr=3, ena=1: rst_n low for exactly 4 cycles, then 3 inc pulses each 4 high/4 low. ena=1 and done coincide at cycle 37 after acceptance. cur_addr=3.
- req addr=0, ena=0: zero inc pulses, done at cycle 13, ctrl_ena stays 0, cur_valid=1.
- With TT_MUX_SEL_INCR_EN, select 3 then 5:
  - the second sequence shows no rst_n pulse, 2 inc pulses, done at cycle 21
  - a following select of 1 takes the full path with rst_n pulsed
- Assert reset_n low during the 2nd inc pulse: all outputs go to reset values asynchronously (same timestep). After release, cur_valid=0 and a new request completes normally.
- ADDR_W=4, addr=15 with req_valid held high: exactly 15 inc pulses. A second request held during busy is accepted only on the first IDLE cycle after done.
